multicycle_ctrl: RTL and testbench

- Multi-cycle control sequencer for the five-stage datapath (yIF, yID, yEX, yDM, yWB).
- Replaces bench-side opcode decoding with an FSM that steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Generates RegWrite/ALUSrc/Mem2Reg/MemRead/MemWrite/op, PC and IR write enables and next-PC select, with a memory-ready handshake and a timeout.

---
 rtl/ctrl_pkg.sv | 39 +++
 rtl/multicycle_ctrl_alu_op_decode.sv | 31 +++
 rtl/multicycle_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle control sequencer:
// FSM states, opcode/ALU-op encodings, pc_sel and fault codes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } ctrl_state_e;

  localparam logic [6:0] OPC_R   = 7'h33;
  localparam logic [6:0] OPC_I   = 7'h13;
  localparam logic [6:0] OPC_LD  = 7'h03;
  localparam logic [6:0] OPC_ST  = 7'h23;
  localparam logic [6:0] OPC_BR  = 7'h63;
  localparam logic [6:0] OPC_JAL = 7'h6F;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  localparam logic [1:0] PC_SEL_PC4 = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_JAL = 2'b10;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  function automatic logic is_legal_opcode(input logic [6:0] opc);
    return (opc inside {OPC_R, OPC_I, OPC_LD, OPC_ST, OPC_BR, OPC_JAL});
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_op_decode.sv
// Combinational ALU-op map from the latched opcode/funct fields.
module alu_op_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned OP_W = 3
) (
  input  logic [6:0]      opcode_i,
  input  logic [2:0]      funct3_i,
  input  logic            funct7_5_i,
  output logic [OP_W-1:0] op_o
);

  logic [2:0] op3;

  always_comb begin
    op3 = ALU_ADD;
    if (opcode_i == OPC_BR) begin
      op3 = ALU_SUB;
    end else if (opcode_i == OPC_R) begin
      case (funct3_i)
        3'b000:  op3 = funct7_5_i ? ALU_SUB : ALU_ADD;
        3'b111:  op3 = ALU_AND;
        3'b110:  op3 = ALU_OR;
        default: op3 = ALU_ADD;
      endcase
    end
  end

  assign op_o = OP_W'(op3);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// handshake and timeout. Optional perf counters under CTRL_PERF_EN.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned OP_W        = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stop,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            ir_we,
  output logic            pc_we,
  output logic [1:0]      pc_sel,
  output logic            RegWrite,
  output logic            ALUSrc,
  output logic            Mem2Reg,
  output logic            MemRead,
  output logic            MemWrite,
  output logic [OP_W-1:0] op,
  output logic            busy,
  output logic [1:0]      fault
`ifdef CTRL_PERF_EN
 ,output logic [31:0]     cycle_cnt,
  output logic [31:0]     retired_cnt
`endif
);

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  ctrl_state_e     state_q, state_d;
  logic [6:0]      opc_q, opc_d;
  logic [2:0]      f3_q, f3_d;
  logic            f75_q, f75_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [1:0]      fault_q, fault_d;
  logic            eoi;
  logic [OP_W-1:0] dec_op;

  alu_op_decode #(
    .OP_W(OP_W)
  ) u_alu_op_decode (
    .opcode_i  (opc_q),
    .funct3_i  (f3_q),
    .funct7_5_i(f75_q),
    .op_o      (dec_op)
  );

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    f3_d    = f3_q;
    f75_d   = f75_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    eoi     = 1'b0;
    case (state_q)
      IDLE:   if (start) state_d = FETCH;
      FETCH:  state_d = DECODE;
      DECODE: begin
        if (!is_legal_opcode(opcode)) begin
          state_d = HALT;
          fault_d = FAULT_ILLEGAL;
        end else begin
          state_d = EXEC;
          opc_d   = opcode;
          f3_d    = funct3;
          f75_d   = funct7_5;
        end
      end
      EXEC: begin
        case (opc_q)
          OPC_BR:         eoi = 1'b1;
          OPC_LD, OPC_ST: state_d = MEM;
          default:        state_d = WB;
        endcase
      end
      MEM: begin
        // mem_ready is tested first so a response on the timeout cycle wins
        if (mem_ready) begin
          cnt_d = '0;
          if (opc_q == OPC_LD) state_d = WB;
          else                 eoi = 1'b1;
        end else if ((cnt_q + 8'd1) == TMO) begin
          cnt_d   = '0;
          state_d = HALT;
          fault_d = FAULT_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WB:      eoi = 1'b1;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    if (eoi) state_d = stop ? IDLE : FETCH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opc_q   <= '0;
      f3_q    <= '0;
      f75_q   <= 1'b0;
      cnt_q   <= '0;
      fault_q <= FAULT_NONE;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      f3_q    <= f3_d;
      f75_q   <= f75_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // Decoded from registered state only; zero/mem_ready gate the PC update
  // in the cycle the datapath reports them, so reset forces every strobe low.
  always_comb begin
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PC_SEL_PC4;
    RegWrite = 1'b0;
    ALUSrc   = 1'b0;
    Mem2Reg  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    op       = '0;
    case (state_q)
      FETCH: ir_we = 1'b1;
      EXEC: begin
        ALUSrc = (opc_q != OPC_R) && (opc_q != OPC_BR);
        op     = dec_op;
        if (opc_q == OPC_BR) begin
          pc_we  = 1'b1;
          pc_sel = zero ? PC_SEL_BR : PC_SEL_PC4;
        end
      end
      MEM: begin
        ALUSrc   = 1'b1;
        op       = OP_W'(ALU_ADD);
        MemRead  = (opc_q == OPC_LD);
        MemWrite = (opc_q == OPC_ST);
        pc_we    = (opc_q == OPC_ST) && mem_ready;
      end
      WB: begin
        RegWrite = 1'b1;
        pc_we    = 1'b1;
        Mem2Reg  = (opc_q == OPC_LD);
        pc_sel   = (opc_q == OPC_JAL) ? PC_SEL_JAL : PC_SEL_PC4;
      end
      default: ;
    endcase
  end

  assign busy  = (state_q != IDLE) && (state_q != HALT);
  assign fault = fault_q;

`ifdef CTRL_PERF_EN
  logic [31:0] cyc_q, ret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (busy) cyc_q <= cyc_q + 32'd1;
      if (eoi)  ret_q <= ret_q + 32'd1;
    end
  end

  assign cycle_cnt   = cyc_q;
  assign retired_cnt = ret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected control vectors
// are queued by the driver and consumed by a negedge monitor while busy.
module tb_multicycle_ctrl;

  localparam int unsigned TMO = 15;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, funct7_5, zero, mem_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        ir_we, pc_we, RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite, busy;
  logic [1:0]  pc_sel, fault;
  logic [2:0]  op;
`ifdef CTRL_PERF_EN
  logic [31:0] cycle_cnt, retired_cnt;
`endif

  multicycle_ctrl #(
    .MEM_TIMEOUT(TMO),
    .OP_W       (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_sel     (pc_sel),
    .RegWrite   (RegWrite),
    .ALUSrc     (ALUSrc),
    .Mem2Reg    (Mem2Reg),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .op         (op),
    .busy       (busy),
    .fault      (fault)
`ifdef CTRL_PERF_EN
   ,.cycle_cnt  (cycle_cnt),
    .retired_cnt(retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] v;
    string       tag;
  } rec_t;

  rec_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          dut_idle;
  int unsigned exp_cyc, exp_ret;
  logic [11:0] act_v;

  assign act_v = {ir_we, pc_we, pc_sel, RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite, op};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] pack(input logic irw, input logic pcw, input logic [1:0] sel,
                                       input logic rw, input logic as, input logic m2r,
                                       input logic mr, input logic mw, input logic [2:0] aop);
    return {irw, pcw, sel, rw, as, m2r, mr, mw, aop};
  endfunction

  function automatic bit legal(input logic [6:0] o);
    return o == 7'h33 || o == 7'h13 || o == 7'h03 || o == 7'h23 || o == 7'h63 || o == 7'h6F;
  endfunction

  function automatic logic [2:0] alu_ref(input logic [6:0] o, input logic [2:0] f3, input logic f75);
    if (o == 7'h63) return 3'b110;
    if (o != 7'h33) return 3'b010;
    if (f3 == 3'b000) return f75 ? 3'b110 : 3'b010;
    if (f3 == 3'b111) return 3'b000;
    if (f3 == 3'b110) return 3'b001;
    return 3'b010;
  endfunction

  task automatic push(input logic [11:0] v, input string tag);
    rec_t r;
    r.v   = v;
    r.tag = tag;
    exp_q.push_back(r);
  endtask

  // Monitor: each busy cycle consumes one expected vector; idle cycles must be quiet.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_busy", {20'd0, act_v}, 32'hDEAD);
        end else begin
          rec_t r;
          r = exp_q.pop_front();
          check(r.tag, {20'd0, act_v}, {20'd0, r.v});
        end
      end else begin
        check("idle_quiet", {20'd0, act_v}, 32'd0);
      end
    end
  end

  task automatic reset_dut();
    rst_n = 1'b0;
    start = 1'b0; stop = 1'b0; zero = 1'b0; mem_ready = 1'b0;
    opcode = '0; funct3 = '0; funct7_5 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    exp_cyc = 0; exp_ret = 0; dut_idle = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", {31'd0, busy}, 32'd1);
    dut_idle = 1'b0;
  endtask

  // Drives one instruction starting in FETCH. abort_at>0 stops driving after
  // that many cycles (no post-checks); the caller handles the aftermath.
  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                           input logic z, input int unsigned waits, input bit stp,
                           input int unsigned abort_at);
    bit ok, ld, st, br, jal, tmo, in_mem;
    int unsigned len;
    ok  = legal(opc);
    ld  = (opc == 7'h03);
    st  = (opc == 7'h23);
    br  = (opc == 7'h63);
    jal = (opc == 7'h6F);
    tmo = ok && (ld || st) && waits >= TMO;
    push(pack(1, 0, 2'b00, 0, 0, 0, 0, 0, 3'b000), "fetch");
    push(12'd0, "decode");
    len = 2;
    if (ok) begin
      push(pack(0, br, (br && z) ? 2'b01 : 2'b00, 0, !(opc == 7'h33 || br), 0, 0, 0,
                alu_ref(opc, f3, f75)), "exec");
      len++;
      if (ld || st) begin
        for (int unsigned i = 0; i < waits && i < TMO; i++) begin
          push(pack(0, 0, 2'b00, 0, 1, 0, ld, st, 3'b010), "mem_wait");
          len++;
        end
        if (!tmo) begin
          push(pack(0, st, 2'b00, 0, 1, 0, ld, st, 3'b010), "mem_done");
          len++;
        end
      end
      if (!tmo && !br && !st) begin
        push(pack(0, 1, jal ? 2'b10 : 2'b00, 1, 0, ld, 0, 0, 3'b000), "wb");
        len++;
      end
    end
    if (abort_at != 0) begin
      while (exp_q.size() > abort_at) void'(exp_q.pop_back());
      len = abort_at;
    end
    for (int unsigned k = 0; k < len; k++) begin
      opcode   = (k == 1) ? opc : 7'($urandom);
      funct3   = (k == 1) ? f3  : 3'($urandom);
      funct7_5 = (k == 1) ? f75 : 1'($urandom);
      zero     = (k == 2) ? z   : 1'($urandom);
      in_mem   = ok && (ld || st) && k >= 3 && k <= 3 + waits;
      mem_ready = in_mem ? (k == 3 + waits) : 1'($urandom);
      stop     = (k == len - 1) ? stp : 1'($urandom);
      start    = 1'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0; stop = 1'b0; mem_ready = 1'b0;
    exp_cyc += len;
    if (abort_at == 0) begin
      check("queue_drained", exp_q.size(), 32'd0);
      if (!ok) begin
        check("fault_illegal", {30'd0, fault}, 32'd1);
        check("halt_not_busy", {31'd0, busy}, 32'd0);
      end else if (tmo) begin
        check("fault_timeout", {30'd0, fault}, 32'd2);
        check("halt_not_busy", {31'd0, busy}, 32'd0);
      end else begin
        exp_ret++;
        check("fault_none", {30'd0, fault}, 32'd0);
        check("busy_after_instr", {31'd0, busy}, {31'd0, !stp});
        dut_idle = stp;
      end
`ifdef CTRL_PERF_EN
      check("cycle_cnt", cycle_cnt, exp_cyc);
      check("retired_cnt", retired_cnt, exp_ret);
`endif
    end
  endtask

  function automatic logic [6:0] rand_legal();
    logic [6:0] tbl [6];
    tbl = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F};
    return tbl[$urandom_range(0, 5)];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ill;
    reset_dut();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_fault", {30'd0, fault}, 32'd0);
    check("reset_outputs", {20'd0, act_v}, 32'd0);
    @(posedge clk); #1;

    do_start();
    run_instr(7'h33, 3'b000, 1'b1, 1'b0, 0, 1'b0, 0);
    run_instr(7'h03, 3'($urandom), 1'b0, 1'b0, 3, 1'b0, 0);
    run_instr(7'h63, 3'($urandom), 1'b0, 1'b1, 0, 1'b0, 0);
    run_instr(7'h63, 3'($urandom), 1'b0, 1'b0, 0, 1'b1, 0);

    for (int i = 0; i < 40; i++) begin
      logic [6:0] o;
      int unsigned w;
      if (dut_idle) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        do_start();
      end
      o = rand_legal();
      w = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 14) : $urandom_range(0, 3);
      run_instr(o, 3'($urandom), 1'($urandom), 1'($urandom), w, ($urandom_range(0, 3) == 0), 0);
    end

    // store never acknowledged -> timeout halt; start must not revive it
    if (dut_idle) do_start();
    run_instr(7'h23, 3'($urandom), 1'b0, 1'b0, 100, 1'b0, 0);
    repeat (3) begin
      start = 1'b1;
      @(posedge clk); #1;
      check("halt_ignores_start", {31'd0, busy}, 32'd0);
      check("halt_fault_sticky", {30'd0, fault}, 32'd2);
    end
    start = 1'b0;

    reset_dut();
    check("reset_clears_fault", {30'd0, fault}, 32'd0);
    do_start();
    run_instr(7'h7F, 3'($urandom), 1'b0, 1'b0, 0, 1'b0, 0);
    reset_dut();
    do_start();
    do ill = 7'($urandom); while (legal(ill));
    run_instr(ill, 3'($urandom), 1'b0, 1'b0, 0, 1'b0, 0);

    // asynchronous reset in the second MEM cycle of a store
    reset_dut();
    do_start();
    run_instr(7'h23, 3'($urandom), 1'b0, 1'b0, 6, 1'b0, 4);
    check("memwrite_before_reset", {31'd0, MemWrite}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("memwrite_async_drop", {31'd0, MemWrite}, 32'd0);
    check("reset_mid_busy", {31'd0, busy}, 32'd0);
    check("reset_mid_queue", exp_q.size(), 32'd0);
    reset_dut();

`ifdef CTRL_PERF_EN
    do_start();
    run_instr(7'h33, 3'($urandom), 1'($urandom), 1'b0, 0, 1'b0, 0);
    run_instr(7'h33, 3'($urandom), 1'($urandom), 1'b0, 0, 1'b0, 0);
    run_instr(7'h33, 3'($urandom), 1'($urandom), 1'b0, 0, 1'b1, 0);
    check("perf_three_retired", retired_cnt, 32'd3);
    check("perf_twelve_cycles", cycle_cnt, 32'd12);
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
